uart_rx_fifo_ctrl: RTL and testbench



---
 rtl/uart_pkg.sv | 41 ++++
 rtl/uart_rx_fifo_mem.sv | 33 +++
 rtl/uart_rx_fifo_ctrl.sv | 178 +++++++++++++++++
 tb/tb_uart_rx_fifo_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive buffer.
//   - receive-trigger (trig_sel) encodings and the threshold helper
//   - per-character status bit positions (parity, framing, break)
//   - rx entry layout {status, data} at the default character geometry
package uart_pkg;

    // Per-character status bit positions inside the STAT_W status field.
    localparam int STAT_PE = 0;
    localparam int STAT_FE = 1;
    localparam int STAT_BI = 2;

    // Default character geometry.
    localparam int RX_DATA_W = 8;
    localparam int RX_STAT_W = 3;

    // Receive trigger level encodings.
    localparam logic [1:0] TRIG_1    = 2'b00;
    localparam logic [1:0] TRIG_4    = 2'b01;
    localparam logic [1:0] TRIG_8    = 2'b10;
    localparam logic [1:0] TRIG_DM2  = 2'b11;

    // One stored receive entry: status sits above the character.
    typedef struct packed {
        logic [RX_STAT_W-1:0] status;
        logic [RX_DATA_W-1:0] data;
    } rx_entry_t;

    // Occupancy at which the data-available indication asserts.
    function automatic int unsigned rx_trig_threshold(input logic [1:0] sel,
                                                      input int unsigned depth);
        int unsigned thr;
        case (sel)
            TRIG_1:  thr = 1;
            TRIG_4:  thr = 4;
            TRIG_8:  thr = 8;
            default: thr = depth - 2;
        endcase
        return thr;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// uart_rx_fifo_mem: storage array for the receive FIFO.
//   DEPTH entries of W bits, synchronous write, asynchronous read.
// Ports:
//   i_clk    clock
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address
//   o_rdata  read data (combinational from i_raddr)
module uart_rx_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int W     = 11
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [W-1:0]             i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [W-1:0]             o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    // No reset: contents are only observable through valid pointers.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// uart_rx_fifo_ctrl: UART receive buffer controller.
// Holds completed characters and their error flags in a first-word-fall-
// through FIFO, arbitrates receiver writes against register reads, and
// produces data-available, character-timeout, overrun and error summaries.
//
// Optional feature macro: UART_RX_TIMEOUT_EN
//   defined   - character timeout counter and o_timeout_irq implemented
//   undefined - i_char_tick ignored, o_timeout_irq tied low
//
// Ports:
//   i_pclk        clock
//   i_preset      synchronous active-high reset
//   i_rx_en       receiver enable; low holds the FIFO flushed
//   i_flush       single-cycle FIFO clear
//   i_wr_valid    character load strobe
//   i_wr_data     received character
//   i_wr_status   status flags of that character {break, framing, parity}
//   i_rd_req      single-cycle pop
//   i_ovr_clr     clears the sticky overrun flag
//   i_trig_sel    receive trigger select (1, 4, 8, DEPTH-2)
//   i_char_tick   one pulse per character time
//   o_rd_data     head character, 0 when empty
//   o_rd_status   head status, 0 when empty
//   o_empty       no entries stored
//   o_full        DEPTH entries stored
//   o_level       occupancy
//   o_overrun     sticky, a character was lost
//   o_fifo_err    some stored entry has nonzero status
//   o_rx_irq      occupancy at or above trigger level
//   o_timeout_irq character timeout
module uart_rx_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int DATA_W        = 8,
    parameter int STAT_W        = 3,
    parameter int TIMEOUT_CHARS = 4
) (
    input  logic                     i_pclk,
    input  logic                     i_preset,
    input  logic                     i_rx_en,
    input  logic                     i_flush,
    input  logic                     i_wr_valid,
    input  logic [DATA_W-1:0]        i_wr_data,
    input  logic [STAT_W-1:0]        i_wr_status,
    input  logic                     i_rd_req,
    input  logic                     i_ovr_clr,
    input  logic [1:0]               i_trig_sel,
    input  logic                     i_char_tick,
    output logic [DATA_W-1:0]        o_rd_data,
    output logic [STAT_W-1:0]        o_rd_status,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overrun,
    output logic                     o_fifo_err,
    output logic                     o_rx_irq,
    output logic                     o_timeout_irq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = DATA_W + STAT_W;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic [LVL_W-1:0] r_err_cnt;
    logic             r_overrun;

    logic             w_empty;
    logic             w_full;
    logic             w_clear;
    logic             w_wr_acc;
    logic             w_rd_acc;
    logic             w_drop;
    logic             w_err_inc;
    logic             w_err_dec;
    logic [ENT_W-1:0] w_head;
    logic [STAT_W-1:0] w_head_status;
    logic [LVL_W-1:0] w_thresh;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LVL_W'(DEPTH));
    // A disabled receiver behaves as a flush held every cycle.
    assign w_clear = i_flush | ~i_rx_en;

    // A write into a full FIFO still fits when the head leaves this cycle.
    assign w_wr_acc = ~w_clear & i_wr_valid & (~w_full | i_rd_req);
    assign w_rd_acc = ~w_clear & i_rd_req & ~w_empty;
    assign w_drop   = ~w_clear & i_wr_valid & w_full & ~i_rd_req;

    assign w_head_status = w_head[ENT_W-1:DATA_W];
    assign w_err_inc     = w_wr_acc & (|i_wr_status);
    assign w_err_dec     = w_rd_acc & (|w_head_status);

    uart_rx_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_mem (
        .i_clk   (i_pclk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata ({i_wr_status, i_wr_data}),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head)
    );

    always_ff @(posedge i_pclk) begin
        if (i_preset || w_clear) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
            case ({w_err_inc, w_err_dec})
                2'b10:   r_err_cnt <= r_err_cnt + LVL_W'(1);
                2'b01:   r_err_cnt <= r_err_cnt - LVL_W'(1);
                default: r_err_cnt <= r_err_cnt;
            endcase
        end
    end

    // Overrun survives flushes; a new loss outranks a same-cycle clear.
    always_ff @(posedge i_pclk) begin
        if (i_preset) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (i_ovr_clr) begin
            r_overrun <= 1'b0;
        end
    end

    assign w_thresh = LVL_W'(rx_trig_threshold(i_trig_sel, DEPTH));

    assign o_rd_data   = w_empty ? '0 : w_head[DATA_W-1:0];
    assign o_rd_status = w_empty ? '0 : w_head_status;
    assign o_empty     = w_empty;
    assign o_full      = w_full;
    assign o_level     = r_level;
    assign o_overrun   = r_overrun;
    assign o_fifo_err  = (r_err_cnt != '0);
    assign o_rx_irq    = (r_level >= w_thresh);

`ifdef UART_RX_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CHARS + 1);

    logic [TMO_W-1:0] r_tmo_cnt;

    // Counts idle character times only while something is waiting.
    always_ff @(posedge i_pclk) begin
        if (i_preset || w_clear || w_wr_acc || w_rd_acc || w_empty) begin
            r_tmo_cnt <= '0;
        end else if (i_char_tick && (r_tmo_cnt != TMO_W'(TIMEOUT_CHARS))) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
    end

    assign o_timeout_irq = (r_tmo_cnt == TMO_W'(TIMEOUT_CHARS));
`else
    logic w_unused;
    assign w_unused      = ^{i_char_tick, TIMEOUT_CHARS[0]};
    assign o_timeout_irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
module tb_uart_rx_fifo_ctrl;
    import uart_pkg::*;

`ifdef UART_RX_TIMEOUT_EN
    localparam logic TMO_ON = 1'b1;
`else
    localparam logic TMO_ON = 1'b0;
`endif

    typedef struct packed {
        logic       rx_en;
        logic       flush;
        logic       wr_valid;
        logic [7:0] wr_data;
        logic [2:0] wr_status;
        logic       rd_req;
        logic       ovr_clr;
        logic [1:0] trig_sel;
        logic       char_tick;
    } in_t;

    typedef struct packed {
        logic [7:0] rd_data;
        logic [2:0] rd_status;
        logic       empty;
        logic       full;
        logic [4:0] level;
        logic       overrun;
        logic       fifo_err;
        logic       rx_irq;
        logic       timeout_irq;
    } out_t;

    typedef struct {
        string name;
        in_t   i;
        out_t  o;
    } vec_t;

    logic       pclk = 1'b0;
    logic       preset;
    logic       rx_en, flush, wr_valid, rd_req, ovr_clr, char_tick;
    logic [7:0] wr_data;
    logic [2:0] wr_status;
    logic [1:0] trig_sel;
    logic [7:0] rd_data;
    logic [2:0] rd_status;
    logic       empty, full, overrun, fifo_err, rx_irq, timeout_irq;
    logic [4:0] level;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- clock / reset ----------------
    always #5 pclk = ~pclk;

    uart_rx_fifo_ctrl #(
        .DEPTH(16), .DATA_W(8), .STAT_W(3), .TIMEOUT_CHARS(4)
    ) dut (
        .i_pclk        (pclk),
        .i_preset      (preset),
        .i_rx_en       (rx_en),
        .i_flush       (flush),
        .i_wr_valid    (wr_valid),
        .i_wr_data     (wr_data),
        .i_wr_status   (wr_status),
        .i_rd_req      (rd_req),
        .i_ovr_clr     (ovr_clr),
        .i_trig_sel    (trig_sel),
        .i_char_tick   (char_tick),
        .o_rd_data     (rd_data),
        .o_rd_status   (rd_status),
        .o_empty       (empty),
        .o_full        (full),
        .o_level       (level),
        .o_overrun     (overrun),
        .o_fifo_err    (fifo_err),
        .o_rx_irq      (rx_irq),
        .o_timeout_irq (timeout_irq)
    );

    // ---------------- vector builders ----------------
    function automatic in_t mk_in(input logic wv, input logic [7:0] d,
                                  input logic [2:0] s, input logic rd,
                                  input logic [1:0] ts);
        in_t v;
        v.rx_en = 1'b1; v.flush = 1'b0; v.wr_valid = wv; v.wr_data = d;
        v.wr_status = s; v.rd_req = rd; v.ovr_clr = 1'b0; v.trig_sel = ts;
        v.char_tick = 1'b0;
        return v;
    endfunction

    function automatic out_t mk_out(input logic [7:0] d, input logic [2:0] s,
                                    input logic e, input logic f,
                                    input logic [4:0] lvl, input logic ovr,
                                    input logic err, input logic rx,
                                    input logic tmo);
        out_t o;
        o.rd_data = d; o.rd_status = s; o.empty = e; o.full = f; o.level = lvl;
        o.overrun = ovr; o.fifo_err = err; o.rx_irq = rx; o.timeout_irq = tmo;
        return o;
    endfunction

    // ---------------- driver ----------------
    task automatic apply(input in_t v);
        @(negedge pclk);
        rx_en = v.rx_en; flush = v.flush; wr_valid = v.wr_valid;
        wr_data = v.wr_data; wr_status = v.wr_status; rd_req = v.rd_req;
        ovr_clr = v.ovr_clr; trig_sel = v.trig_sel; char_tick = v.char_tick;
        @(posedge pclk);
        #1;
    endtask

    task automatic idle();
        apply(mk_in(1'b0, 8'h00, 3'd0, 1'b0, 2'b00));
    endtask

    task automatic tick(input int n);
        in_t v;
        v = mk_in(1'b0, 8'h00, 3'd0, 1'b0, 2'b00);
        v.char_tick = 1'b1;
        for (int k = 0; k < n; k++) apply(v);
    endtask

    // ---------------- scoreboard check ----------------
    task automatic check(input string name, input out_t e);
        out_t a;
        a.rd_data = rd_data; a.rd_status = rd_status; a.empty = empty;
        a.full = full; a.level = level; a.overrun = overrun;
        a.fifo_err = fifo_err; a.rx_irq = rx_irq; a.timeout_irq = timeout_irq;
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got data=%h st=%b empty=%b full=%b lvl=%0d ovr=%b err=%b rx=%b tmo=%b ; want data=%h st=%b empty=%b full=%b lvl=%0d ovr=%b err=%b rx=%b tmo=%b",
                     name, a.rd_data, a.rd_status, a.empty, a.full, a.level,
                     a.overrun, a.fifo_err, a.rx_irq, a.timeout_irq,
                     e.rd_data, e.rd_status, e.empty, e.full, e.level,
                     e.overrun, e.fifo_err, e.rx_irq, e.timeout_irq);
        end
    endtask

    // ---------------- test ----------------
    vec_t tbl[20];
    localparam logic [2:0] ST_FE = 3'(1 << STAT_FE);
    localparam logic [2:0] ST_PE = 3'(1 << STAT_PE);

    initial begin
        in_t  v;
        out_t rst_o;
        rst_o = mk_out(8'h00, 3'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Table: {inputs, expected outputs after the edge}
        tbl[0]  = '{"w41",    mk_in(1, 8'h41, 3'd0, 0, 2'b00), mk_out(8'h41, 3'd0, 0, 0, 5'd1, 0, 0, 1, 0)};
        tbl[1]  = '{"w42",    mk_in(1, 8'h42, 3'd0, 0, 2'b00), mk_out(8'h41, 3'd0, 0, 0, 5'd2, 0, 0, 1, 0)};
        tbl[2]  = '{"w43",    mk_in(1, 8'h43, 3'd0, 0, 2'b00), mk_out(8'h41, 3'd0, 0, 0, 5'd3, 0, 0, 1, 0)};
        tbl[3]  = '{"rd1",    mk_in(0, 8'h00, 3'd0, 1, 2'b00), mk_out(8'h42, 3'd0, 0, 0, 5'd2, 0, 0, 1, 0)};
        tbl[4]  = '{"rd2",    mk_in(0, 8'h00, 3'd0, 1, 2'b00), mk_out(8'h43, 3'd0, 0, 0, 5'd1, 0, 0, 1, 0)};
        tbl[5]  = '{"rd3",    mk_in(0, 8'h00, 3'd0, 1, 2'b00), mk_out(8'h00, 3'd0, 1, 0, 5'd0, 0, 0, 0, 0)};
        tbl[6]  = '{"rd_emp", mk_in(0, 8'h00, 3'd0, 1, 2'b00), mk_out(8'h00, 3'd0, 1, 0, 5'd0, 0, 0, 0, 0)};
        tbl[7]  = '{"trig4a", mk_in(1, 8'h11, 3'd0, 0, 2'b01), mk_out(8'h11, 3'd0, 0, 0, 5'd1, 0, 0, 0, 0)};
        tbl[8]  = '{"trig4b", mk_in(1, 8'h12, 3'd0, 0, 2'b01), mk_out(8'h11, 3'd0, 0, 0, 5'd2, 0, 0, 0, 0)};
        tbl[9]  = '{"trig4c", mk_in(1, 8'h13, 3'd0, 0, 2'b01), mk_out(8'h11, 3'd0, 0, 0, 5'd3, 0, 0, 0, 0)};
        tbl[10] = '{"trig4d", mk_in(1, 8'h14, 3'd0, 0, 2'b01), mk_out(8'h11, 3'd0, 0, 0, 5'd4, 0, 0, 1, 0)};
        tbl[11] = '{"trig4r", mk_in(0, 8'h00, 3'd0, 1, 2'b01), mk_out(8'h12, 3'd0, 0, 0, 5'd3, 0, 0, 0, 0)};
        tbl[12] = '{"flush",  mk_in(0, 8'h00, 3'd0, 0, 2'b00), mk_out(8'h00, 3'd0, 1, 0, 5'd0, 0, 0, 0, 0)};
        tbl[12].i.flush = 1'b1;
        tbl[13] = '{"err_w",  mk_in(1, 8'h55, ST_FE, 0, 2'b00), mk_out(8'h55, ST_FE, 0, 0, 5'd1, 0, 1, 1, 0)};
        tbl[14] = '{"err_w2", mk_in(1, 8'h66, 3'd0, 0, 2'b00), mk_out(8'h55, ST_FE, 0, 0, 5'd2, 0, 1, 1, 0)};
        tbl[15] = '{"err_rd", mk_in(0, 8'h00, 3'd0, 1, 2'b00), mk_out(8'h66, 3'd0, 0, 0, 5'd1, 0, 0, 1, 0)};
        tbl[16] = '{"rw_inc", mk_in(1, 8'h77, ST_PE, 1, 2'b00), mk_out(8'h77, ST_PE, 0, 0, 5'd1, 0, 1, 1, 0)};
        tbl[17] = '{"rw_dec", mk_in(1, 8'h78, 3'd0, 1, 2'b00), mk_out(8'h78, 3'd0, 0, 0, 5'd1, 0, 0, 1, 0)};
        tbl[18] = '{"rd_last",mk_in(0, 8'h00, 3'd0, 1, 2'b00), mk_out(8'h00, 3'd0, 1, 0, 5'd0, 0, 0, 0, 0)};
        tbl[19] = '{"rx_off", mk_in(1, 8'h99, 3'd0, 0, 2'b00), mk_out(8'h00, 3'd0, 1, 0, 5'd0, 0, 0, 0, 0)};
        tbl[19].i.rx_en = 1'b0;

        // Reset
        preset = 1'b1;
        rx_en = 1'b1; flush = 0; wr_valid = 0; wr_data = 0; wr_status = 0;
        rd_req = 0; ovr_clr = 0; trig_sel = 0; char_tick = 0;
        repeat (3) @(posedge pclk);
        #1;
        check("reset", rst_o);
        @(negedge pclk);
        preset = 1'b0;

        // Table-driven vectors
        for (int n = 0; n < 20; n++) begin
            apply(tbl[n].i);
            check(tbl[n].name, tbl[n].o);
        end

        // Fill to full, then one more write is dropped
        for (int i = 0; i < 16; i++) apply(mk_in(1, 8'(i), 3'd0, 0, 2'b00));
        check("fill16", mk_out(8'h00, 3'd0, 0, 1, 5'd16, 0, 0, 1, 0));
        apply(mk_in(1, 8'h99, 3'd0, 0, 2'b00));
        check("ovr_set", mk_out(8'h00, 3'd0, 0, 1, 5'd16, 1, 0, 1, 0));
        for (int i = 0; i < 16; i++) begin
            apply(mk_in(0, 8'h00, 3'd0, 1, 2'b00));
            if (i < 15)
                check("drain", mk_out(8'(i + 1), 3'd0, 0, 0, 5'(15 - i), 1, 0, 1, 0));
            else
                check("drain_end", mk_out(8'h00, 3'd0, 1, 0, 5'd0, 1, 0, 0, 0));
        end
        v = mk_in(0, 8'h00, 3'd0, 0, 2'b00);
        v.ovr_clr = 1'b1;
        apply(v);
        check("ovr_clr", rst_o);

        // Refill with the DEPTH-2 trigger and watch it cross at 14
        for (int i = 0; i < 16; i++) begin
            apply(mk_in(1, 8'(8'h20 + i), 3'd0, 0, 2'b11));
            check("trig14", mk_out(8'h20, 3'd0, 0, (i == 15), 5'(i + 1), 0, 0, (i + 1 >= 14), 0));
        end
        apply(mk_in(1, 8'hA0, 3'd0, 1, 2'b00));
        check("full_rw", mk_out(8'h21, 3'd0, 0, 1, 5'd16, 0, 0, 1, 0));
        v = mk_in(1, 8'hA1, 3'd0, 0, 2'b00);
        v.ovr_clr = 1'b1;
        apply(v);
        check("set_wins", mk_out(8'h21, 3'd0, 0, 1, 5'd16, 1, 0, 1, 0));

        // Flush keeps overrun and beats a same-cycle write
        v = mk_in(0, 8'h00, 3'd0, 0, 2'b00);
        v.flush = 1'b1;
        apply(v);
        for (int i = 0; i < 5; i++) apply(mk_in(1, 8'(8'h30 + i), 3'd0, 0, 2'b00));
        check("lvl5", mk_out(8'h30, 3'd0, 0, 0, 5'd5, 1, 0, 1, 0));
        v = mk_in(1, 8'h3F, 3'd0, 0, 2'b00);
        v.flush = 1'b1;
        apply(v);
        check("flush_wr", mk_out(8'h00, 3'd0, 1, 0, 5'd0, 1, 0, 0, 0));

        // Character timeout
        apply(mk_in(1, 8'hC0, 3'd0, 0, 2'b00));
        tick(3);
        check("tmo_3", mk_out(8'hC0, 3'd0, 0, 0, 5'd1, 1, 0, 1, 0));
        tick(1);
        check("tmo_4", mk_out(8'hC0, 3'd0, 0, 0, 5'd1, 1, 0, 1, TMO_ON));
        tick(1);
        check("tmo_sat", mk_out(8'hC0, 3'd0, 0, 0, 5'd1, 1, 0, 1, TMO_ON));
        apply(mk_in(0, 8'h00, 3'd0, 1, 2'b00));
        check("tmo_rd", mk_out(8'h00, 3'd0, 1, 0, 5'd0, 1, 0, 0, 0));
        tick(5);
        check("tmo_empty", mk_out(8'h00, 3'd0, 1, 0, 5'd0, 1, 0, 0, 0));
        apply(mk_in(1, 8'hC1, 3'd0, 0, 2'b00));
        tick(4);
        check("tmo_again", mk_out(8'hC1, 3'd0, 0, 0, 5'd1, 1, 0, 1, TMO_ON));
        apply(mk_in(1, 8'hC2, 3'd0, 0, 2'b00));
        check("tmo_wrclr", mk_out(8'hC1, 3'd0, 0, 0, 5'd2, 1, 0, 1, 0));
        idle();
        check("idle", mk_out(8'hC1, 3'd0, 0, 0, 5'd2, 1, 0, 1, 0));

        // Reset in the middle of filling
        apply(mk_in(1, 8'hD0, ST_FE, 0, 2'b00));
        @(negedge pclk);
        preset = 1'b1;
        wr_valid = 1'b1; wr_data = 8'hD1; wr_status = 3'd0;
        @(posedge pclk);
        #1;
        check("preset_mid", rst_o);
        @(negedge pclk);
        preset = 1'b0;
        wr_valid = 1'b0;
        @(posedge pclk);
        #1;
        check("post_reset", rst_o);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
